univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH)+1, width of the shift-amount input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  parallel load request.
REQ-006 SHALL have port d_in  input  WIDTH  parallel load data.
REQ-007 SHALL have port start  input  1  begin a multi-cycle shift operation.
REQ-008 SHALL have port mode  input  3  operation: 0 SLL, 1 SRL, 2 ROL, 3 ROR, 4 SRA, 5-7 reserved.
REQ-009 SHALL have port amount  input  AMT_W  number of single-bit shift steps.
REQ-010 SHALL have port ser_in  input  1  fill bit for SLL and SRL.
REQ-011 SHALL have port d_out  output  WIDTH  current register contents.
REQ-012 SHALL have port ser_out  output  1  bit ejected by the most recent shift step.
REQ-013 SHALL have port busy  output  1  high while shift steps are in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 In IDLE, load=1 SHALL set reg<=d_in on that edge, with priority over start.
REQ-017 In IDLE, start=1 with load=0 SHALL latch mode and amount; amount>0 goes to SHIFT with count=amount, amount=0 goes to DONE with reg unchanged.
REQ-018 Each edge in SHIFT SHALL perform exactly one step on reg using the latched mode and decrement count; when count==1, the FSM goes to DONE.
REQ-019 Latency: with start sampled at edge k and amount N>0, steps SHALL occur at edges k+1..k+N; busy=1 in those N cycles; done=1 for the single cycle after edge k+N.
REQ-020 Step rules: SLL {reg[W-2:0],ser_in}; SRL {ser_in,reg[W-1:1]}; ROL {reg[W-2:0],reg[W-1]}; ROR {reg[0],reg[W-1:1]}; SRA {reg[W-1],reg[W-1:1]}.
REQ-021 ser_out SHALL register the ejected bit on each step: reg[W-1] for left modes and reg[0] for right modes, and SHALL hold its value otherwise.
REQ-022 Reserved modes SHALL consume N cycles with busy and done timing per REQ-019, leaving reg and ser_out unchanged.
REQ-023 Amounts up to 2^AMT_W-1 SHALL be executed literally, with no clamping (SLL by >=WIDTH yields all ser_in; ROL by WIDTH restores the original value).
REQ-024 load=1 in SHIFT SHALL abort the operation: reg<=d_in, FSM goes to IDLE, and no done pulse is issued.
REQ-025 start in SHIFT or DONE SHALL be ignored; DONE SHALL always return to IDLE after one cycle.
REQ-026 load in DONE SHALL load d_in, and the FSM SHALL still go to IDLE.
REQ-027 d_out SHALL equal reg combinationally, with no extra latency.

Reset
REQ-028 rst=1 at an edge SHALL force reg=0, ser_out=0, count=0 and state IDLE, so that busy=0 and done=0, overriding load and start in every state, including mid-operation.

Structure
REQ-029 Package shift_pkg SHALL hold the mode encodings (localparams or enum) and the FSM state enum.
REQ-030 Sub-module shift_step SHALL be a combinational single-step shifter (inputs reg, mode, ser_in; outputs next reg, ejected bit), instantiated once.

Verification (WIDTH=8)
REQ-031 load 0xA5; start SLL, amount 3, ser_in 0 -> busy for 3 cycles, then d_out=0x28, ser_out=1, done pulse 1 cycle.
REQ-032 load 0x81; start ROR, amount 8 -> busy for 8 cycles, then d_out=0x81, ser_out=1, done pulse.
REQ-033 load 0x80; start SRA, amount 2 -> d_out=0xE0, ser_out=0; then SRL, amount 1, ser_in 1 -> d_out=0xF0.
REQ-034 start with amount 0 -> busy never high, done high in the next cycle, d_out unchanged.
REQ-035 load 0x0F; start SLL, amount 4; assert load with d_in 0x3C in the second busy cycle -> d_out=0x3C, busy=0 on the next cycle, no done pulse.
REQ-036 rst during SHIFT (SRL, amount 5, reg 0xFF) -> next cycle d_out=0x00, ser_out=0, busy=0, done=0; a subsequent start behaves per REQ-019.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   - MODE_* : encodings of the 3-bit mode input (5..7 are reserved and
//              behave as timed no-ops).
//   - state_e: control FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_ROL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_SRA = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter.
// Ports:
//   cur    - current register value
//   mode   - operation (shift_pkg MODE_* encodings)
//   ser_in - fill bit for SLL / SRL
//   nxt    - register value after one step
//   eject  - bit shifted out by this step
//   active - 1 when mode is a real operation; 0 for reserved modes, in
//            which case nxt == cur and eject must not be captured
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt,
  output logic             eject,
  output logic             active
);

  always_comb begin
    nxt    = cur;
    eject  = 1'b0;
    active = 1'b1;
    case (mode)
      MODE_SLL: begin
        nxt   = {cur[WIDTH-2:0], ser_in};
        eject = cur[WIDTH-1];
      end
      MODE_SRL: begin
        nxt   = {ser_in, cur[WIDTH-1:1]};
        eject = cur[0];
      end
      MODE_ROL: begin
        nxt   = {cur[WIDTH-2:0], cur[WIDTH-1]};
        eject = cur[WIDTH-1];
      end
      MODE_ROR: begin
        nxt   = {cur[0], cur[WIDTH-1:1]};
        eject = cur[0];
      end
      MODE_SRA: begin
        nxt   = {cur[WIDTH-1], cur[WIDTH-1:1]};
        eject = cur[0];
      end
      default: begin
        active = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with multi-cycle, one-bit-per-clock shifting.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load,d_in - parallel load (wins over start; aborts a shift in progress)
//   start     - begin an operation of `amount` steps using `mode`
//   mode      - 0 SLL, 1 SRL, 2 ROL, 3 ROR, 4 SRA, 5-7 reserved (timed no-op)
//   amount    - number of single-bit steps (0 means complete immediately)
//   ser_in    - fill bit for SLL/SRL, sampled on every step
//   d_out     - register contents
//   ser_out   - bit ejected by the most recent real step
//   busy      - high while steps are being performed
//   done      - one-cycle pulse after the final step (not after an abort)
//
// Handshake: start is only accepted in IDLE without load; while busy or
// during the done cycle start is ignored. mode and amount are captured when
// start is accepted, so they may change freely afterwards.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [WIDTH-1:0] sh_reg;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] count;
  logic             ser_q;

  logic [WIDTH-1:0] step_nxt;
  logic             step_eject;
  logic             step_active;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur    (sh_reg),
    .mode   (mode_q),
    .ser_in (ser_in),
    .nxt    (step_nxt),
    .eject  (step_eject),
    .active (step_active)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sh_reg <= '0;
      mode_q <= '0;
      count  <= '0;
      ser_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            sh_reg <= d_in;
          end else if (start) begin
            mode_q <= mode;
            count  <= amount;
            state  <= (amount == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (load) begin
            // Abort: no further steps and no done pulse.
            sh_reg <= d_in;
            count  <= '0;
            state  <= ST_IDLE;
          end else begin
            sh_reg <= step_nxt;
            if (step_active) ser_q <= step_eject;
            count  <= count - 1'b1;
            if (count == AMT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (load) sh_reg <= d_in;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_out   = sh_reg;
  assign ser_out = ser_q;
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios followed by random
// operations, all checked against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int W     = 8;
  localparam int AMT_W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             load;
  logic [W-1:0]     d_in;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             ser_in;
  logic [W-1:0]     d_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  univ_shift_reg #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .d_in    (d_in),
    .start   (start),
    .mode    (mode),
    .amount  (amount),
    .ser_in  (ser_in),
    .d_out   (d_out),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  logic [W-1:0] mdl_reg;
  logic         mdl_so;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of applying `n` steps of mode `m` as whole-word arithmetic.
  function automatic void model(input logic [W-1:0] v, input int m, input int n,
                                input logic sin, input logic so_in,
                                output logic [W-1:0] res, output logic so);
    int mask;
    int vi;
    int sv;
    int r;
    mask = (1 << W) - 1;
    vi   = int'(v);
    sv   = {{(32-W){v[W-1]}}, v};
    r    = n % W;
    res  = v;
    so   = so_in;
    if (n == 0) return;
    case (m)
      0: begin
        res = W'(((vi << n) | (sin ? ((1 << n) - 1) : 0)) & mask);
        if (n <= W) so = v[W-n]; else so = sin;
      end
      1: begin
        res = W'((vi >> n) | (sin ? (~(mask >> n) & mask) : 0));
        if (n <= W) so = v[n-1]; else so = sin;
      end
      2: begin
        res = W'(((vi << r) | (vi >> (W - r))) & mask);
        so  = res[0];
      end
      3: begin
        res = W'(((vi >> r) | (vi << (W - r))) & mask);
        so  = res[W-1];
      end
      4: begin
        res = W'((sv >>> n) & mask);
        if (n <= W) so = v[n-1]; else so = v[W-1];
      end
      default: begin
      end
    endcase
  endfunction

  // driver tasks
  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    d_in = v;
    tick();
    load = 1'b0;
    mdl_reg = v;
    chk("load_dout", 32'(d_out), 32'(v));
    chk("load_busy", 32'(busy), 0);
  endtask

  task automatic run_op(input int m, input int n, input logic sin, input bit noise);
    logic [W-1:0] er;
    logic         eso;
    model(mdl_reg, m, n, sin, mdl_so, er, eso);
    mode   = 3'(m);
    amount = AMT_W'(n);
    ser_in = sin;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_on", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        mode   = 3'($urandom_range(0, 7));
        amount = AMT_W'($urandom_range(0, 15));
      end
      tick();
    end
    if (noise) start = 1'($urandom_range(0, 1));
    chk("busy_off", 32'(busy), 0);
    chk("done_pulse", 32'(done), 1);
    chk("result", 32'(d_out), 32'(er));
    chk("ser_out", 32'(ser_out), 32'(eso));
    tick();
    start = 1'b0;
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("result_hold", 32'(d_out), 32'(er));
    mdl_reg = er;
    mdl_so  = eso;
  endtask

  initial begin
    logic [W-1:0] tmp_reg;
    logic         tmp_so;

    rst = 1'b1; load = 1'b0; d_in = '0; start = 1'b0;
    mode = '0; amount = '0; ser_in = 1'b0;
    mdl_reg = '0; mdl_so = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_ser_out", 32'(ser_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // SLL 3 of 0xA5
    do_load(8'hA5);
    run_op(0, 3, 1'b0, 1'b0);
    chk("sll3_const", 32'(d_out), 32'h28);

    // ROR 8 of 0x81 comes back unchanged
    do_load(8'h81);
    run_op(3, 8, 1'b0, 1'b0);
    chk("ror8_const", 32'(d_out), 32'h81);

    // SRA 2 then SRL 1 with ser_in 1
    do_load(8'h80);
    run_op(4, 2, 1'b0, 1'b0);
    chk("sra2_const", 32'(d_out), 32'hE0);
    run_op(1, 1, 1'b1, 1'b0);
    chk("srl1_const", 32'(d_out), 32'hF0);

    // amount 0 completes immediately
    run_op(2, 0, 1'b0, 1'b0);

    // boundary amounts: SLL beyond width, ROL by width, reserved mode
    do_load(8'h5A);
    run_op(0, 10, 1'b1, 1'b0);
    chk("sll10_fill", 32'(d_out), 32'hFF);
    do_load(8'h96);
    run_op(2, 8, 1'b0, 1'b0);
    chk("rol8_const", 32'(d_out), 32'h96);
    run_op(6, 5, 1'b1, 1'b0);
    run_op(1, 15, 1'b0, 1'b0);

    // abort with load in the second busy cycle
    do_load(8'h0F);
    mode = 3'd0; amount = AMT_W'(4); ser_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy1", 32'(busy), 1);
    tick();
    chk("abort_busy2", 32'(busy), 1);
    load = 1'b1; d_in = 8'h3C;
    tick();
    load = 1'b0;
    model(8'h0F, 0, 1, 1'b0, mdl_so, tmp_reg, tmp_so);
    mdl_reg = 8'h3C;
    mdl_so  = tmp_so;
    chk("abort_dout", 32'(d_out), 32'h3C);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ser_out", 32'(ser_out), 32'(mdl_so));
    tick();
    chk("abort_no_done", 32'(done), 0);

    // load during the done cycle
    do_load(8'h33);
    mode = 3'd0; amount = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_done_pulse", 32'(done), 1);
    load = 1'b1; d_in = 8'hC7;
    tick();
    load = 1'b0;
    mdl_reg = 8'hC7;
    chk("ld_done_dout", 32'(d_out), 32'hC7);
    chk("ld_done_idle", 32'(done), 0);
    run_op(1, 1, 1'b0, 1'b0);

    // reset mid-operation
    do_load(8'hFF);
    mode = 3'd1; amount = AMT_W'(5); ser_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_reg = '0;
    mdl_so  = 1'b0;
    chk("mid_rst_dout", 32'(d_out), 0);
    chk("mid_rst_ser_out", 32'(ser_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    do_load(8'h81);
    run_op(2, 3, 1'b0, 1'b0);

    // random operations, with start/mode/amount noise while busy
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) do_load(W'($urandom_range(0, 255)));
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
